// File: rtl/race_game_ctrl.sv
// -----------------------------------------------------------------------------
// race_game_ctrl
//   Game-state controller for the racing game. Sits after the position
//   generator: every frame tick it looks at the player car and the two enemy
//   cars, detects collisions, counts enemies that wrapped past the bottom of
//   the screen as score, and manages lives. Its state gates the movement
//   counters (run_en) and drives the overlay/LED indicators.
//
//   Build option:
//     SCORE_BCD_EN  defined   -> score is 4-digit packed BCD, saturating at 9999
//                   undefined -> score is 16-bit binary, saturating at 16'hFFFF
//
//   Ports:
//     FPGACLK      in   1   system clock
//     RESET        in   1   asynchronous reset, active-low
//     frame_tick   in   1   one-cycle pulse per movement update
//     start_pulse  in   1   one-cycle start request (keyboard decode)
//     player_x     in  10   player car left edge
//     enemy1_y     in  10   enemy 1 top edge
//     enemy2_y     in  10   enemy 2 top edge
//     run_en       out  1   1 = movement counters may advance
//     state        out  2   0 IDLE, 1 PLAYING, 2 HIT, 3 GAME_OVER
//     lives        out  3   remaining lives
//     score        out 16   passed-enemy count
//     hit_flash    out  1   blink signal for the display while in HIT
// -----------------------------------------------------------------------------
module race_game_ctrl #(
  parameter logic [9:0] ENEMY1_X    = 10'd200,
  parameter logic [9:0] ENEMY2_X    = 10'd360,
  parameter logic [9:0] PLAYER_Y    = 10'd400,
  parameter logic [9:0] CAR_W       = 10'd40,
  parameter logic [9:0] CAR_H       = 10'd60,
  parameter int         START_LIVES = 3,
  parameter int         HIT_TICKS   = 4
) (
  input  logic        FPGACLK,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic        start_pulse,
  input  logic [9:0]  player_x,
  input  logic [9:0]  enemy1_y,
  input  logic [9:0]  enemy2_y,
  output logic        run_en,
  output logic [1:0]  state,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic        hit_flash
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_HIT       = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam int HIT_CNT_W = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
  localparam logic [HIT_CNT_W-1:0] HIT_LAST = HIT_CNT_W'(HIT_TICKS - 1);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

`ifdef SCORE_BCD_EN
  localparam logic [15:0] SCORE_MAX = 16'h9999;
`else
  localparam logic [15:0] SCORE_MAX = 16'hFFFF;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,     state_d;
  logic [2:0]             lives_q,     lives_d;
  logic [15:0]            score_q,     score_d;
  logic                   hit_flash_q, hit_flash_d;
  logic [9:0]             prev_y1_q,   prev_y1_d;
  logic [9:0]             prev_y2_q,   prev_y2_d;
  logic [HIT_CNT_W-1:0]   hit_cnt_q,   hit_cnt_d;

  // ---------------------------------------------------------------------------
  // Geometry helpers
  // ---------------------------------------------------------------------------
  // Horizontal overlap: |px - ex| < CAR_W. The difference is taken in 11-bit
  // signed so a player left of the lane produces a negative value, not a wrap.
  function automatic logic h_overlap(input logic [9:0] px, input logic [9:0] ex);
    logic signed [10:0] diff;
    logic        [10:0] mag;
    diff = $signed({1'b0, px}) - $signed({1'b0, ex});
    mag  = diff[10] ? $unsigned(-diff) : $unsigned(diff);
    return mag < {1'b0, CAR_W};
  endfunction

  // Vertical overlap with the fixed player row; the extra bit keeps
  // ey + CAR_H from wrapping for enemies near the bottom of the 10-bit range.
  function automatic logic v_overlap(input logic [9:0] ey);
    logic [10:0] e_top, e_bot, p_top, p_bot;
    e_top = {1'b0, ey};
    e_bot = {1'b0, ey} + {1'b0, CAR_H};
    p_top = {1'b0, PLAYER_Y};
    p_bot = {1'b0, PLAYER_Y} + {1'b0, CAR_H};
    return (e_bot > p_top) && (e_top < p_bot);
  endfunction

  // Saturating score increment by 0, 1 or 2.
`ifdef SCORE_BCD_EN
  function automatic logic [15:0] score_add(input logic [15:0] s, input logic [1:0] inc);
    logic [15:0] r;
    logic [4:0]  d;
    logic [4:0]  c;
    r = '0;
    c = {3'b000, inc};
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, s[4*i +: 4]} + c;
      if (d > 5'd9) begin
        r[4*i +: 4] = 4'(d - 5'd10);
        c           = 5'd1;
      end else begin
        r[4*i +: 4] = d[3:0];
        c           = 5'd0;
      end
    end
    // A carry out of the thousands digit means we passed 9999.
    return (c != 5'd0) ? SCORE_MAX : r;
  endfunction
`else
  function automatic logic [15:0] score_add(input logic [15:0] s, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, s} + {15'd0, inc};
    return sum[16] ? SCORE_MAX : sum[15:0];
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Per-tick events
  // ---------------------------------------------------------------------------
  logic       hit1, hit2, any_hit;
  logic       pass1, pass2;
  logic [1:0] n_pass;

  always_comb begin
    hit1    = h_overlap(player_x, ENEMY1_X) && v_overlap(enemy1_y);
    hit2    = h_overlap(player_x, ENEMY2_X) && v_overlap(enemy2_y);
    // Two simultaneous hits still cost only one life.
    any_hit = hit1 || hit2;
    // An enemy whose y went down since the last tick has wrapped past the bottom.
    pass1   = enemy1_y < prev_y1_q;
    pass2   = enemy2_y < prev_y2_q;
    n_pass  = {1'b0, pass1} + {1'b0, pass2};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given its hold value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    hit_flash_d = hit_flash_q;
    prev_y1_d   = prev_y1_q;
    prev_y2_d   = prev_y2_q;
    hit_cnt_d   = hit_cnt_q;

    // Previous enemy positions track every tick regardless of game state.
    if (frame_tick) begin
      prev_y1_d = enemy1_y;
      prev_y2_d = enemy2_y;
    end

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        // A start request takes priority over any tick on the same cycle.
        if (start_pulse) begin
          state_d     = ST_PLAYING;
          lives_d     = LIVES_INIT;
          score_d     = '0;
          hit_flash_d = 1'b0;
          hit_cnt_d   = '0;
          prev_y1_d   = enemy1_y;
          prev_y2_d   = enemy2_y;
        end
      end

      ST_PLAYING: begin
        if (frame_tick) begin
          if (any_hit) begin
            // A collision suppresses any pass scored on the same tick.
            if (lives_q > 3'd1) begin
              lives_d   = lives_q - 3'd1;
              state_d   = ST_HIT;
              hit_cnt_d = '0;
            end else begin
              lives_d = 3'd0;
              state_d = ST_GAME_OVER;
            end
          end else begin
            score_d = score_add(score_q, n_pass);
          end
        end
      end

      ST_HIT: begin
        if (frame_tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            state_d     = ST_PLAYING;
            hit_flash_d = 1'b0;
            hit_cnt_d   = '0;
          end else begin
            hit_flash_d = ~hit_flash_q;
            hit_cnt_d   = hit_cnt_q + HIT_CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values and the order of statements below does not matter.
  always_ff @(posedge FPGACLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      lives_q     <= 3'd0;
      score_q     <= 16'd0;
      hit_flash_q <= 1'b0;
      prev_y1_q   <= 10'd0;
      prev_y2_q   <= 10'd0;
      hit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      hit_flash_q <= hit_flash_d;
      prev_y1_q   <= prev_y1_d;
      prev_y2_q   <= prev_y2_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign state     = state_q;
  assign run_en    = (state_q == ST_PLAYING);
  assign lives     = lives_q;
  assign score     = score_q;
  assign hit_flash = hit_flash_q;

endmodule

// File: tb/tb_race_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_race_game_ctrl
//   Directed self-checking bench for race_game_ctrl (default binary score
//   build). Enemy 2 lane is moved to x=220 so a player at x=210 can overlap
//   both enemies at once.
// -----------------------------------------------------------------------------
module tb_race_game_ctrl;

  logic        FPGACLK;
  logic        RESET;
  logic        frame_tick;
  logic        start_pulse;
  logic [9:0]  player_x;
  logic [9:0]  enemy1_y;
  logic [9:0]  enemy2_y;
  logic        run_en;
  logic [1:0]  state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        hit_flash;

  int checks;
  int passed;

  race_game_ctrl #(
    .ENEMY2_X (10'd220)
  ) dut (
    .FPGACLK     (FPGACLK),
    .RESET       (RESET),
    .frame_tick  (frame_tick),
    .start_pulse (start_pulse),
    .player_x    (player_x),
    .enemy1_y    (enemy1_y),
    .enemy2_y    (enemy2_y),
    .run_en      (run_en),
    .state       (state),
    .lives       (lives),
    .score       (score),
    .hit_flash   (hit_flash)
  );

  initial begin
    FPGACLK = 1'b0;
    forever #5 FPGACLK = ~FPGACLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic ru,
                           input logic [2:0] li, input logic [15:0] sc, input logic fl);
    check({tag, ".state"},     {14'd0, state},     {14'd0, st});
    check({tag, ".run_en"},    {15'd0, run_en},    {15'd0, ru});
    check({tag, ".lives"},     {13'd0, lives},     {13'd0, li});
    check({tag, ".score"},     score,              sc);
    check({tag, ".hit_flash"}, {15'd0, hit_flash}, {15'd0, fl});
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the clock edge.
  task automatic step(input logic tk, input logic st, input logic [9:0] px,
                      input logic [9:0] y1, input logic [9:0] y2);
    frame_tick  = tk;
    start_pulse = st;
    player_x    = px;
    enemy1_y    = y1;
    enemy2_y    = y2;
    @(posedge FPGACLK);
    #1;
    frame_tick  = 1'b0;
    start_pulse = 1'b0;
  endtask

  int         exp_sc;
  logic [9:0] v;

  initial begin
    checks      = 0;
    passed      = 0;
    RESET       = 1'b0;
    frame_tick  = 1'b0;
    start_pulse = 1'b0;
    player_x    = 10'd0;
    enemy1_y    = 10'd0;
    enemy2_y    = 10'd0;

    // Reset state
    repeat (3) @(posedge FPGACLK);
    #1;
    check_all("reset", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    RESET = 1'b1;

    // Ticks without start keep the game idle
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
    check_all("idle_ticks", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);

    // Start: prev_y resampled as (470, 100)
    step(1'b0, 1'b1, 10'd0, 10'd470, 10'd100);
    check_all("start", 2'd1, 1'b1, 3'd3, 16'd0, 1'b0);

    // Enemy 1 wraps 470 -> 10, enemy 2 moves down 100 -> 110: one pass
    step(1'b1, 1'b0, 10'd0, 10'd10, 10'd110);
    check_all("pass1", 2'd1, 1'b1, 3'd3, 16'd1, 1'b0);

    // Both enemies wrap on the same tick: +2
    step(1'b1, 1'b0, 10'd0, 10'd5, 10'd50);
    check_all("pass2", 2'd1, 1'b1, 3'd3, 16'd3, 1'b0);

    // Moving down, no pass
    step(1'b1, 1'b0, 10'd0, 10'd20, 10'd60);
    check("nopass.score", score, 16'd3);

    // Without a tick nothing is evaluated even with an overlapping input
    step(1'b0, 1'b0, 10'd210, 10'd380, 10'd60);
    check_all("notick", 2'd1, 1'b1, 3'd3, 16'd3, 1'b0);

    // Single collision with enemy 1 (x=210 vs 200, y=380 vs 400)
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd60);
    check_all("hit1", 2'd2, 1'b0, 3'd2, 16'd3, 1'b0);

    // HIT: flash toggles on every tick, collisions and passes ignored
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd60);
    check_all("hit1.t1", 2'd2, 1'b0, 3'd2, 16'd3, 1'b1);
    step(1'b0, 1'b0, 10'd210, 10'd380, 10'd60);
    check("hit1.idle_cycle.flash", {15'd0, hit_flash}, 16'd1);
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd10);
    check_all("hit1.t2", 2'd2, 1'b0, 3'd2, 16'd3, 1'b0);
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd10);
    check_all("hit1.t3", 2'd2, 1'b0, 3'd2, 16'd3, 1'b1);
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd10);
    check_all("hit1.t4", 2'd1, 1'b1, 3'd2, 16'd3, 1'b0);

    // Both enemies collide, enemy 1 also passes (380 -> 350): one life, no score
    step(1'b1, 1'b0, 10'd210, 10'd350, 10'd380);
    check_all("hit2", 2'd2, 1'b0, 3'd1, 16'd3, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'd0, 10'd350, 10'd350);
    check_all("hit2.done", 2'd1, 1'b1, 3'd1, 16'd3, 1'b0);

    // Last life lost -> GAME_OVER
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd350);
    check_all("gameover", 2'd3, 1'b0, 3'd0, 16'd3, 1'b0);

    // Passes in GAME_OVER are not scored
    step(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
    check_all("gameover.hold", 2'd3, 1'b0, 3'd0, 16'd3, 1'b0);

    // Restart with a coincident tick: start wins, prev_y = (500, 500)
    step(1'b1, 1'b1, 10'd0, 10'd500, 10'd500);
    check_all("restart", 2'd1, 1'b1, 3'd3, 16'd0, 1'b0);

    // One pass (enemy 1 500 -> 100), then start_pulse ignored while playing
    step(1'b1, 1'b0, 10'd0, 10'd100, 10'd500);
    check("restart.pass.score", score, 16'd1);
    step(1'b0, 1'b1, 10'd0, 10'd100, 10'd500);
    check_all("start_ignored", 2'd1, 1'b1, 3'd3, 16'd1, 1'b0);

    // Drive the score to 16'hFFFE with descending enemy positions
    step(1'b1, 1'b0, 10'd0, 10'd1023, 10'd1023);
    step(1'b1, 1'b0, 10'd0, 10'd1022, 10'd1023);
    exp_sc = 2;
    v      = 10'd1022;
    while (exp_sc < 32'h0000_FFFE) begin
      v = (v == 10'd0) ? 10'd1023 : v - 10'd1;
      step(1'b1, 1'b0, 10'd0, v, v);
      if (v != 10'd1023) exp_sc += 2;
    end
    check("preload.score", score, 16'(exp_sc));
    if (v < 10'd2) begin
      v = 10'd1023;
      step(1'b1, 1'b0, 10'd0, v, v);
    end
    v = v - 10'd1;
    step(1'b1, 1'b0, 10'd0, v, v);
    check_all("sat1", 2'd1, 1'b1, 3'd3, 16'hFFFF, 1'b0);
    v = v - 10'd1;
    step(1'b1, 1'b0, 10'd0, v, v);
    check("sat2.score", score, 16'hFFFF);

    // Enter HIT, then assert reset between clock edges
    step(1'b1, 1'b0, 10'd210, 10'd380, 10'd380);
    check_all("hit3", 2'd2, 1'b0, 3'd2, 16'hFFFF, 1'b0);
    step(1'b1, 1'b0, 10'd0, 10'd380, 10'd380);
    check("hit3.t1.flash", {15'd0, hit_flash}, 16'd1);
    #2;
    RESET = 1'b0;
    #1;
    check_all("async_reset", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    #2;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
    check_all("after_reset", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
